fc_output_quant: RTL and testbench

Downstream stage of the fully-connected accumulator. It takes finished 2·DATA_WIDTH-bit sign-magnitude dot-product sums and, in order:
- applies optional ReLU;
- rescales by an arithmetic right shift with rounding;
- saturates to DATA_WIDTH-bit sign-magnitude;
- buffers results in a small FIFO behind a valid/ready handshake.

Results go to the layer writeback / next-layer input buffer.

---
 rtl/fc_output_quant.sv | 99 +++++++++
 tb/tb_fc_output_quant.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_output_quant.sv
// Output stage of the fully-connected accumulator: optional ReLU, rounding right shift
// and saturation of sign-magnitude sums, then a small FIFO behind valid/ready handshakes.
module fc_output_quant #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [15:0]             sat_count
);
    localparam int IW = 2 * DATA_WIDTH;
    localparam int MW = IW - 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [MW:0] HALF    = {{MW{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic [MW:0] MAX_MAG = {{(MW + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};

    logic [IW-1:0]         s1_data;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  relu_zero;
    logic                  sat;
    logic                  res_sign;
    logic [MW:0]           rounded;
    logic [DATA_WIDTH-2:0] res_mag;
    logic                  accept;
    logic                  push;
    logic                  pop;

    // Magnitude path is one bit wider than the magnitude so the rounding add cannot wrap.
    always_comb begin
        relu_zero = RELU_EN && s1_data[IW-1];
        rounded   = ({1'b0, s1_data[MW-1:0]} + HALF) >> FRAC_SHIFT;
        sat       = !relu_zero && (rounded > MAX_MAG);
        if (relu_zero) begin
            res_mag = '0;
        end else if (sat) begin
            res_mag = '1;
        end else begin
            res_mag = rounded[DATA_WIDTH-2:0];
        end
        res_sign = s1_data[IW-1] && (res_mag != '0);
    end

    // in_ready counts the stage-1 result as occupied, so a pop never feeds back into it.
    assign in_ready  = ({1'b0, count} + (CW + 1)'(s1_valid)) < (CW + 1)'(FIFO_DEPTH);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign accept    = in_valid && in_ready;
    assign push      = s1_valid;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sat_count <= '0;
        end else begin
            s1_valid <= accept;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (push && sat && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_data <= in_data;
        end
        if (push) begin
            mem[wr_ptr] <= {res_sign, res_mag};
        end
    end

endmodule

// File: tb/tb_fc_output_quant.sv
// Bench for fc_output_quant: one ReLU instance and one pass-through instance share the
// same stimulus; a queue-based model predicts each instance's output stream.
module tb_fc_output_quant;
    localparam int DW = 16;
    localparam int FS = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [2*DW-1:0] in_data;
    logic          out_ready;
    logic          r_in_ready, r_out_valid, n_in_ready, n_out_valid;
    logic [DW-1:0] r_out_data, n_out_data;
    logic [15:0]   r_sat_count, n_sat_count;

    fc_output_quant #(.DATA_WIDTH(DW), .FRAC_SHIFT(FS), .FIFO_DEPTH(DEPTH), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
        .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
        .sat_count(r_sat_count));

    fc_output_quant #(.DATA_WIDTH(DW), .FRAC_SHIFT(FS), .FIFO_DEPTH(DEPTH), .RELU_EN(1'b0)) dut_norelu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .sat_count(n_sat_count));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp_r;
        logic [15:0] exp_n;
        int          sat_r;
        int          sat_n;
    } vec_t;

    vec_t        vecs [11];
    int          total = 0;
    int          passed = 0;
    logic [15:0] q_r[$], q_n[$];
    int          msat_r = 0, msat_n = 0;
    int          acc_cnt = 0, pop_cnt_r = 0, pop_cnt_n = 0;
    logic [15:0] last_r, last_n;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Reference: plain integer arithmetic on the magnitude.
    function automatic logic [15:0] model(input logic [31:0] d, input bit relu, output bit sat);
        longint mag, r, maxm;
        sat  = 1'b0;
        mag  = longint'(d[30:0]);
        maxm = (longint'(1) << (DW - 1)) - 1;
        if (relu && d[31]) return 16'h0000;
        r = (mag + (longint'(1) << (FS - 1))) / (longint'(1) << FS);
        if (r > maxm) begin
            r = maxm;
            sat = 1'b1;
        end
        if (r == 0) return 16'h0000;
        return {d[31], r[14:0]};
    endfunction

    // One clock: score handshakes seen before the edge, then advance to 1ns past it.
    task automatic applyStimulus();
        bit s;
        logic [15:0] e;
        if (!rst) begin
            if (in_valid && r_in_ready) begin
                e = model(in_data, 1'b1, s);
                q_r.push_back(e);
                if (s && msat_r < 16'hFFFF) msat_r++;
                acc_cnt++;
            end
            if (in_valid && n_in_ready) begin
                e = model(in_data, 1'b0, s);
                q_n.push_back(e);
                if (s && msat_n < 16'hFFFF) msat_n++;
            end
            if (r_out_valid && out_ready) begin
                checkOutput("relu_pop_nonempty", 32'(q_r.size() != 0), 32'd1);
                if (q_r.size() != 0) checkOutput("relu_order", 32'(r_out_data), 32'(q_r.pop_front()));
                last_r = r_out_data;
                pop_cnt_r++;
            end
            if (n_out_valid && out_ready) begin
                checkOutput("norelu_pop_nonempty", 32'(q_n.size() != 0), 32'd1);
                if (q_n.size() != 0) checkOutput("norelu_order", 32'(n_out_data), 32'(q_n.pop_front()));
                last_n = n_out_data;
                pop_cnt_n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((r_out_valid || n_out_valid || q_r.size() != 0 || q_n.size() != 0) && guard < 60) begin
            applyStimulus();
            guard++;
        end
        checkOutput({name, "_drain_timeout"}, 32'(guard < 60), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00012380, 16'h0124, 16'h0124, 0, 0};
        vecs[1]  = '{32'h00000080, 16'h0001, 16'h0001, 0, 0};
        vecs[2]  = '{32'h0000007F, 16'h0000, 16'h0000, 0, 0};
        vecs[3]  = '{32'h80000180, 16'h0000, 16'h8002, 0, 0};
        vecs[4]  = '{32'h80000000, 16'h0000, 16'h0000, 0, 0};
        vecs[5]  = '{32'h80001000, 16'h0000, 16'h8010, 0, 0};
        vecs[6]  = '{32'h01000000, 16'h7FFF, 16'h7FFF, 1, 1};
        vecs[7]  = '{32'hFFFFFFFF, 16'h0000, 16'hFFFF, 1, 2};
        vecs[8]  = '{32'h007FFF7F, 16'h7FFF, 16'h7FFF, 1, 2};
        vecs[9]  = '{32'h007FFF80, 16'h7FFF, 16'h7FFF, 2, 3};
        vecs[10] = '{32'h8000007F, 16'h0000, 16'h0000, 2, 3};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(r_in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(r_out_valid), 32'd0);
        checkOutput("reset_sat_count", 32'(r_sat_count), 32'd0);
        checkOutput("reset_norelu_sat_count", 32'(n_sat_count), 32'd0);

        // Directed vectors: latency, rounding, ReLU, saturation.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            last_r = 'x; last_n = 'x;
            in_valid = 1'b1; in_data = vecs[i].din;
            applyStimulus();
            in_valid = 1'b0;
            checkOutput($sformatf("v%0d_valid_after_accept", i), 32'(r_out_valid), 32'd0);
            applyStimulus();
            checkOutput($sformatf("v%0d_valid_after_write", i), 32'(r_out_valid), 32'd1);
            applyStimulus();
            checkOutput($sformatf("v%0d_relu_data", i), 32'(last_r), 32'(vecs[i].exp_r));
            checkOutput($sformatf("v%0d_norelu_data", i), 32'(last_n), 32'(vecs[i].exp_n));
            checkOutput($sformatf("v%0d_relu_sat", i), 32'(r_sat_count), 32'(vecs[i].sat_r));
            checkOutput($sformatf("v%0d_norelu_sat", i), 32'(n_sat_count), 32'(vecs[i].sat_n));
        end

        // Backpressure: six items offered with the consumer stalled.
        begin
            logic [31:0] items [6];
            int k;
            for (int i = 0; i < 6; i++) items[i] = 32'h00010000 * (i + 1) + 32'h80;
            out_ready = 1'b0;
            acc_cnt = 0;
            k = 0;
            for (int c = 0; c < 8; c++) begin
                in_valid = 1'b1; in_data = items[k];
                if (r_in_ready) k++;
                applyStimulus();
            end
            checkOutput("bp_accepted", 32'(acc_cnt), 32'd4);
            checkOutput("bp_in_ready_low", 32'(r_in_ready), 32'd0);
            checkOutput("bp_head_stable0", 32'(r_out_data), 32'(q_r[0]));
            applyStimulus();
            checkOutput("bp_head_stable1", 32'(r_out_data), 32'(q_r[0]));
            out_ready = 1'b1;
            pop_cnt_r = 0;
            for (int c = 0; c < 40 && k < 6; c++) begin
                in_valid = 1'b1; in_data = items[k];
                if (r_in_ready) k++;
                applyStimulus();
            end
            drain("bp");
            checkOutput("bp_total_popped", 32'(pop_cnt_r), 32'd6);
        end

        // Continuous transfers with a toggling consumer to wrap the pointers.
        acc_cnt = 0; pop_cnt_r = 0;
        in_valid = 1'b1; in_data = $urandom;
        for (int c = 0; c < 80 && acc_cnt < 10; c++) begin
            out_ready = c[0];
            if (r_in_ready) begin
                applyStimulus();
                in_data = $urandom;
            end else begin
                applyStimulus();
            end
        end
        drain("wrap");
        checkOutput("wrap_accepted", 32'(acc_cnt), 32'd10);
        checkOutput("wrap_popped", 32'(pop_cnt_r), 32'd10);

        // Randomized traffic against the model.
        begin
            bit held;
            held = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (!held) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    case ($urandom_range(0, 3))
                        0: in_data = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 1023))};
                        1: in_data = {$urandom_range(0, 1) == 1, 31'($urandom_range(32'h007F0000, 32'h00810000))};
                        default: in_data = $urandom;
                    endcase
                end
                out_ready = ($urandom_range(0, 2) != 0);
                held = in_valid && !r_in_ready;
                applyStimulus();
            end
            drain("rand");
            checkOutput("rand_relu_sat_count", 32'(r_sat_count), 32'(msat_r));
            checkOutput("rand_norelu_sat_count", 32'(n_sat_count), 32'(msat_n));
        end

        // Reset with three results buffered.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h01000000; applyStimulus();
        in_data = 32'h00012380; applyStimulus();
        in_data = 32'h00000080; applyStimulus();
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("pre_reset_valid", 32'(r_out_valid), 32'd1);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        q_r.delete(); q_n.delete(); msat_r = 0; msat_n = 0;
        checkOutput("mid_reset_out_valid", 32'(r_out_valid), 32'd0);
        checkOutput("mid_reset_in_ready", 32'(r_in_ready), 32'd1);
        checkOutput("mid_reset_sat_count", 32'(r_sat_count), 32'd0);
        in_valid = 1'b1; in_data = 32'h00000180;
        applyStimulus();
        in_valid = 1'b0;
        checkOutput("post_reset_valid_n1", 32'(r_out_valid), 32'd0);
        applyStimulus();
        checkOutput("post_reset_valid_n2", 32'(r_out_valid), 32'd1);
        checkOutput("post_reset_data", 32'(r_out_data), 32'h0002);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("post_reset_alone", 32'(r_out_valid), 32'd0);
        checkOutput("post_reset_queue_empty", 32'(q_r.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
